die_roll_ctrl: RTL and testbench

Roll sequencer for the six-sided die design. Turns a raw push-button into a complete roll: synchronises and edge-detects the press, then spins the displayed face through a decelerating series of pseudo-random steps. It settles on a final face of 1..6 and holds it until the next press. Sits between the top-level `ui_in` button bit and the `uo_out` pip LEDs, and is the only block that sequences the die face.

---
 rtl/die_pkg.sv | 56 +++++
 rtl/die_btn_cond.sv | 83 ++++++++
 rtl/die_roll_ctrl.sv | 127 ++++++++++++
 tb/tb_die_roll_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/die_pkg.sv
// ============================================================================
// Module   : die_pkg
// Desc     : Shared roll-sequencer types, LFSR constants, pip patterns and
//            the face-stepping helper used by die_roll_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package die_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SPIN = 2'd1,
        ST_DONE = 2'd2
    } die_state_t;

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam logic [6:0] c_pips_blank = 7'h00;
    localparam logic [6:0] c_pips_one   = 7'h08;
    localparam logic [6:0] c_pips_two   = 7'h41;
    localparam logic [6:0] c_pips_three = 7'h49;
    localparam logic [6:0] c_pips_four  = 7'h63;
    localparam logic [6:0] c_pips_five  = 7'h6B;
    localparam logic [6:0] c_pips_six   = 7'h77;

    function automatic logic [6:0] face_to_pips(input logic [2:0] cur);
        case (cur)
            3'd1:    return c_pips_one;
            3'd2:    return c_pips_two;
            3'd3:    return c_pips_three;
            3'd4:    return c_pips_four;
            3'd5:    return c_pips_five;
            3'd6:    return c_pips_six;
            default: return c_pips_blank;
        endcase
    endfunction

    // Advance by 1..5 positions, so the face always differs from the last one
    function automatic logic [2:0] next_face(input logic [2:0] cur, input logic [2:0] rnd);
        logic [2:0] r;
        logic [3:0] sum;
        r   = (rnd >= 3'd5) ? rnd - 3'd5 : rnd;
        sum = (cur == 3'd0) ? 4'd1 : {1'b0, cur};
        sum = sum + {1'b0, r};
        if (sum >= 4'd6) begin
            sum = sum - 4'd6;
        end
        return sum[2:0] + 3'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/die_btn_cond.sv
// ============================================================================
// Module   : die_btn_cond
// Desc     : Button conditioning: 2-flop synchroniser, optional debouncer
//            (DIE_ROLL_DEBOUNCE_EN) and registered rising-edge detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module die_btn_cond #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic roll_btn,
    output logic press
);

    logic r_sync1;
    logic r_sync2;
    logic r_level_d;
    logic r_press;
    logic w_level;

    if (DEBOUNCE_CYC < 1) begin : g_bad_debounce_cyc
        $error("DEBOUNCE_CYC must be at least 1");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else if (ena) begin
            r_sync1 <= roll_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DIE_ROLL_DEBOUNCE_EN
    localparam int c_db_w = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [c_db_w-1:0] r_db_cnt;
    logic              r_db_level;

    // Rise only after DEBOUNCE_CYC consecutive highs; drop on the first low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
        end else if (ena) begin
            if (!r_sync2) begin
                r_db_cnt   <= '0;
                r_db_level <= 1'b0;
            end else if (!r_db_level) begin
                if (r_db_cnt == c_db_w'(DEBOUNCE_CYC - 1)) begin
                    r_db_level <= 1'b1;
                end else begin
                    r_db_cnt <= r_db_cnt + c_db_w'(1);
                end
            end
        end
    end

    assign w_level = r_db_level;
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else if (ena) begin
            r_level_d <= w_level;
            r_press   <= w_level & ~r_level_d;
        end
    end

    assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/die_roll_ctrl.sv
// ============================================================================
// Module   : die_roll_ctrl
// Desc     : Die roll sequencer: button press starts a decelerating spin of
//            pseudo-random face steps, settling on a face 1..6.
// Config   : define DIE_ROLL_DEBOUNCE_EN to debounce the button input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module die_roll_ctrl #(
    parameter int TICK_DIV     = 16,
    parameter int STEPS        = 12,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       roll_btn,
    output logic [2:0] face,
    output logic [6:0] pips,
    output logic       busy,
    output logic       done
);

    import die_pkg::*;

    localparam int c_cnt_w  = $clog2(TICK_DIV * STEPS + 1);
    localparam int c_step_w = $clog2(STEPS + 1);

    die_state_t          r_state;
    die_state_t          w_state_next;
    logic [c_step_w-1:0] r_step;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_reload;
    logic [7:0]          r_lfsr;
    logic [7:0]          w_lfsr_next;
    logic [2:0]          r_face;
    logic [6:0]          r_pips;
    logic                w_press;
    logic                w_expire;
    logic                w_last;

    die_btn_cond #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_cond (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .roll_btn (roll_btn),
        .press    (w_press)
    );

    assign w_expire    = (r_cnt == c_cnt_w'(1));
    assign w_last      = (r_step == c_step_w'(STEPS));
    assign w_reload    = c_cnt_w'(TICK_DIV) * c_cnt_w'(r_step + c_step_w'(1));
    assign w_lfsr_next = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (ena) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_press) w_state_next = ST_SPIN;
            ST_SPIN: if (w_expire && w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_SPIN: busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // LFSR free-runs in every state so press timing seeds the outcome
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
            r_step <= '0;
            r_cnt  <= '0;
            r_face <= 3'd0;
            r_pips <= c_pips_blank;
        end else if (ena) begin
            r_lfsr <= w_lfsr_next;
            r_pips <= face_to_pips(r_face);
            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        r_step <= c_step_w'(1);
                        r_cnt  <= c_cnt_w'(TICK_DIV);
                    end
                end
                ST_SPIN: begin
                    if (w_expire) begin
                        r_face <= next_face(r_face, r_lfsr[2:0]);
                        if (w_last) begin
                            r_cnt <= '0;
                        end else begin
                            r_step <= r_step + c_step_w'(1);
                            r_cnt  <= w_reload;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign face = r_face;
    assign pips = r_pips;

endmodule

`default_nettype wire

// File: tb/tb_die_roll_ctrl.sv
// ============================================================================
// Module   : tb_die_roll_ctrl
// Desc     : Self-checking bench for die_roll_ctrl against a cycle-indexed
//            roll model (honours DIE_ROLL_DEBOUNCE_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_die_roll_ctrl;

    localparam int TICK_DIV     = 2;
    localparam int STEPS        = 3;
    localparam int DEBOUNCE_CYC = 4;
    localparam int SPIN_LEN     = TICK_DIV * STEPS * (STEPS + 1) / 2;
`ifdef DIE_ROLL_DEBOUNCE_EN
    localparam int LAT      = 3 + DEBOUNCE_CYC;
    localparam int MIN_HOLD = DEBOUNCE_CYC;
`else
    localparam int LAT      = 3;
    localparam int MIN_HOLD = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       roll_btn;
    logic [2:0] face;
    logic [6:0] pips;
    logic       busy;
    logic       done;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_lfsr;
    logic [7:0] m_prev;
    int         m_face;
    logic [5:0] seen;

    die_roll_ctrl #(
        .TICK_DIV     (TICK_DIV),
        .STEPS        (STEPS),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .roll_btn (roll_btn),
        .face     (face),
        .pips     (pips),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Polynomial division step x^8+x^6+x^5+x^4+1, LSB shifted out
    function automatic logic [7:0] lfsr_adv(input logic [7:0] s);
        logic [7:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 8'hB8;
        return n;
    endfunction

    function automatic int model_next_face(input int f, input logic [7:0] l);
        int r;
        int fe;
        r  = int'(l[2:0]) % 5;
        fe = (f == 0) ? 1 : f;
        return ((fe - 1) + 1 + r) % 6 + 1;
    endfunction

    // Bits: 0 TL, 1 TR, 2 ML, 3 C, 4 MR, 5 BL, 6 BR
    function automatic logic [6:0] model_pips(input int f);
        logic [6:0] p;
        p = 7'd0;
        case (f)
            1: p[3] = 1'b1;
            2: begin p[0] = 1'b1; p[6] = 1'b1; end
            3: begin p[0] = 1'b1; p[3] = 1'b1; p[6] = 1'b1; end
            4: begin p[0] = 1'b1; p[1] = 1'b1; p[5] = 1'b1; p[6] = 1'b1; end
            5: begin p[0] = 1'b1; p[1] = 1'b1; p[3] = 1'b1; p[5] = 1'b1; p[6] = 1'b1; end
            6: begin p[0] = 1'b1; p[1] = 1'b1; p[2] = 1'b1; p[4] = 1'b1; p[5] = 1'b1; p[6] = 1'b1; end
            default: p = 7'd0;
        endcase
        return p;
    endfunction

    task automatic tick();
        logic en;
        en = ena & rst_n;
        @(posedge clk);
        m_prev = m_lfsr;
        if (en) m_lfsr = lfsr_adv(m_lfsr);
        #1;
    endtask

    // Drive one roll; e counts enabled edges from the first sampling edge
    task automatic run_roll(input int hold, input int p2, input int off_at, input int off_len,
                            output int done_cnt, output int done_t);
        int         e;
        int         t;
        int         ne;
        int         s;
        int         off_left;
        int         exp_face;
        int         prev_f;
        bit         step_edge;
        logic       exp_busy;
        logic       exp_done;
        logic [6:0] exp_pips;
        e = -1; t = -1; off_left = off_len; done_cnt = 0; done_t = -1; prev_f = 0;
        exp_face = m_face; exp_pips = model_pips(m_face); exp_busy = 1'b0; exp_done = 1'b0;
        while (e < LAT + SPIN_LEN + 2) begin
            if (t > 400) begin
                n_checks++; n_fail++;
                $display("FAIL roll_timeout: e=%0d, required %0d", e, LAT + SPIN_LEN + 2);
                break;
            end
            ne = e + 1;
            roll_btn = (ne < hold) || (ne >= p2 && ne < p2 + MIN_HOLD + 2);
            if (ne == off_at && off_left > 0) begin
                ena = 1'b0; off_left--;
            end else begin
                ena = 1'b1;
            end
            tick(); t++;
            step_edge = 1'b0;
            if (ena) begin
                e++;
                exp_pips = model_pips(exp_face);
                exp_busy = (e >= LAT) && (e < LAT + SPIN_LEN);
                exp_done = (e == LAT + SPIN_LEN);
                s = e - LAT;
                for (int k = 1; k <= STEPS; k++) begin
                    if (s == TICK_DIV * k * (k + 1) / 2) begin
                        prev_f = exp_face;
                        exp_face = model_next_face(exp_face, m_prev);
                        step_edge = 1'b1;
                    end
                end
            end
            n_checks++;
            if (busy !== exp_busy) begin
                n_fail++; $display("FAIL busy t=%0d: got %b, required %b", t, busy, exp_busy);
            end
            n_checks++;
            if (done !== exp_done) begin
                n_fail++; $display("FAIL done t=%0d: got %b, required %b", t, done, exp_done);
            end
            n_checks++;
            if (face !== exp_face[2:0]) begin
                n_fail++; $display("FAIL face t=%0d: got %0d, required %0d", t, face, exp_face);
            end
            n_checks++;
            if (pips !== exp_pips) begin
                n_fail++; $display("FAIL pips t=%0d: got %h, required %h", t, pips, exp_pips);
            end
            if (step_edge) begin
                n_checks++;
                if (face === 3'(prev_f) || !(face >= 3'd1 && face <= 3'd6)) begin
                    n_fail++;
                    $display("FAIL face_step t=%0d: got %0d, required 1..6 and not %0d", t, face, prev_f);
                end
                if (face >= 3'd1 && face <= 3'd6) seen[face - 3'd1] = 1'b1;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_t < 0) done_t = t;
            end
        end
        m_face = exp_face;
        roll_btn = 1'b0;
        ena = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; roll_btn = 1'b0;
        m_lfsr = 8'hA5; m_prev = 8'hA5; m_face = 0;
        repeat (3) tick();
        n_checks++;
        if (face !== 3'd0) begin n_fail++; $display("FAIL reset_face: got %0d, required 0", face); end
        n_checks++;
        if (pips !== 7'h00) begin n_fail++; $display("FAIL reset_pips: got %h, required 00", pips); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_basic_roll();
        int dc;
        int dt;
        run_roll(5, -10, -1, 0, dc, dt);
        n_checks++;
        if (dc != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d, required 1", dc); end
        n_checks++;
        if (dt != LAT + SPIN_LEN) begin
            n_fail++; $display("FAIL basic_done_time: got %0d, required %0d", dt, LAT + SPIN_LEN);
        end
        n_checks++;
        if (!(face >= 3'd1 && face <= 3'd6)) begin
            n_fail++; $display("FAIL basic_final_face: got %0d, required 1..6", face);
        end
        repeat (3) tick();
    endtask

    task automatic test_press_during_spin();
        int dc;
        int dt;
        run_roll(MIN_HOLD, LAT + 4, -1, 0, dc, dt);
        n_checks++;
        if (dc != 1) begin n_fail++; $display("FAIL spin_press_done_count: got %0d, required 1", dc); end
        repeat (6) begin
            tick();
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL spin_press_requeued: busy %b, required 0", busy); end
        end
    endtask

    task automatic test_ena_freeze();
        int dc;
        int dt;
        run_roll(MIN_HOLD, -10, LAT + 5, 10, dc, dt);
        n_checks++;
        if (dt != LAT + SPIN_LEN + 10) begin
            n_fail++; $display("FAIL ena_done_time: got %0d, required %0d", dt, LAT + SPIN_LEN + 10);
        end
        n_checks++;
        if (dc != 1) begin n_fail++; $display("FAIL ena_done_count: got %0d, required 1", dc); end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_roll();
        bit saw_busy;
        bit saw_done;
        for (int i = 0; i < LAT + 5; i++) begin
            roll_btn = (i < MIN_HOLD);
            tick();
        end
        roll_btn = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midroll_busy: got %b, required 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (face !== 3'd0 || pips !== 7'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midroll_reset: face %0d pips %h busy %b done %b, required 0 00 0 0",
                     face, pips, busy, done);
        end
        m_lfsr = 8'hA5; m_face = 0;
        tick();
        rst_n = 1'b1;
        saw_busy = 1'b0; saw_done = 1'b0;
        repeat (30) begin
            tick();
            if (busy === 1'b1) saw_busy = 1'b1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done || saw_busy) begin
            n_fail++; $display("FAIL midroll_after: done seen %b busy seen %b, required 0 0", saw_done, saw_busy);
        end
        n_checks++;
        if (face !== 3'd0) begin n_fail++; $display("FAIL midroll_face_hold: got %0d, required 0", face); end
    endtask

    task automatic test_back_to_back();
        int dc;
        int dt;
        seen = 6'd0;
        for (int r = 0; r < 200; r++) begin
            run_roll(int'($urandom_range(6, MIN_HOLD)), -10, -1, 0, dc, dt);
            n_checks++;
            if (dc != 1) begin n_fail++; $display("FAIL b2b_done_count roll %0d: got %0d, required 1", r, dc); end
            repeat ($urandom_range(5, 0)) tick();
        end
        n_checks++;
        if (seen !== 6'h3F) begin n_fail++; $display("FAIL b2b_faces_seen: got %b, required 111111", seen); end
    endtask

`ifdef DIE_ROLL_DEBOUNCE_EN
    task automatic test_debounce();
        bit saw_busy;
        int dc;
        int dt;
        saw_busy = 1'b0;
        for (int i = 0; i < 18; i++) begin
            roll_btn = (i < DEBOUNCE_CYC - 1);
            tick();
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        n_checks++;
        if (saw_busy) begin n_fail++; $display("FAIL glitch_rolled: busy seen %b, required 0", saw_busy); end
        n_checks++;
        if (face !== 3'(m_face)) begin n_fail++; $display("FAIL glitch_face: got %0d, required %0d", face, m_face); end
        run_roll(6, -10, -1, 0, dc, dt);
        n_checks++;
        if (dc != 1 || dt != LAT + SPIN_LEN) begin
            n_fail++; $display("FAIL debounce_roll: done %0d at %0d, required 1 at %0d", dc, dt, LAT + SPIN_LEN);
        end
        repeat (3) tick();
    endtask
`else
    task automatic test_short_pulse();
        int dc;
        int dt;
        run_roll(1, -10, -1, 0, dc, dt);
        n_checks++;
        if (dc != 1 || dt != LAT + SPIN_LEN) begin
            n_fail++; $display("FAIL short_pulse: done %0d at %0d, required 1 at %0d", dc, dt, LAT + SPIN_LEN);
        end
        repeat (3) tick();
    endtask
`endif

    initial begin
        seen = 6'd0;
        test_reset();
        test_basic_roll();
        test_press_during_spin();
        test_ena_freeze();
`ifdef DIE_ROLL_DEBOUNCE_EN
        test_debounce();
`else
        test_short_pulse();
`endif
        test_back_to_back();
        test_reset_mid_roll();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
